// File: rtl/word_memory_pkg.sv
// Shared definitions for the word_memory block.
//   mem_state_t   : sweep FSM state (IDLE, SWEEP)
//   DEFAULT_WIDTH : default bits per stored word
//   DEFAULT_DEPTH : default number of words (power of two, >= 2)
package mem_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic [0:0] {
        IDLE,
        SWEEP
    } mem_state_t;

endpackage

// File: rtl/word_memory_sweep_counter.sv
// Address counter for the clear sweep of word_memory.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (count returns to 0)
//   en    : advance the count by one on this edge
//   count : current sweep address
//   last  : count is at its terminal value (all ones)
// The counter wraps naturally, so a full sweep leaves it back at 0.
module sweep_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    always_comb begin
        last = &count;
    end

endmodule

// File: rtl/word_memory.sv
// Clocked word store with per-word valid bits, write-first reads and a
// multi-cycle clear sweep.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   addr  : word address for store and read
//   data  : write data
//   store : write data into mem[addr] on this edge (dropped while sweeping
//           or when clear is sampled on the same edge)
//   clear : start a clear sweep (ignored while a sweep is running)
//   Q     : registered read data for addr
//   valid : registered, word at addr written since last reset/clear
//   busy  : clear sweep in progress
module word_memory
    import mem_pkg::*;
#(
    parameter  int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data,
    input  logic              store,
    input  logic              clear,
    output logic [WIDTH-1:0]  Q,
    output logic              valid,
    output logic              busy
);

    mem_state_t        state_q;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  vbit_q;

    logic [ADDR_W-1:0] sweep_idx;
    logic              sweep_last;
    logic              sweeping;
    logic              store_ok;
    logic [WIDTH-1:0]  rd_data;

    always_comb begin
        sweeping = (state_q == SWEEP);
        // clear wins over store on the same IDLE edge
        store_ok = (state_q == IDLE) && store && !clear;
        // Unwritten words read as zero so stale contents never leak out
        rd_data  = vbit_q[addr] ? mem[addr] : '0;
    end

    sweep_counter #(
        .WIDTH (ADDR_W)
    ) u_sweep_counter (
        .clk   (clk),
        .reset (reset),
        .en    (sweeping),
        .count (sweep_idx),
        .last  (sweep_last)
    );

    // Storage array: not reset; a reset mid-sweep leaves it partly swept,
    // which is harmless because every valid bit is cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweeping) begin
                mem[sweep_idx] <= '0;
            end else if (store_ok) begin
                mem[addr] <= data;
            end
        end
    end

    // Sweep FSM, valid bits and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vbit_q  <= '0;
            Q       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q <= SWEEP;
                        busy    <= 1'b1;
                        Q       <= rd_data;
                        valid   <= vbit_q[addr];
                    end else if (store) begin
                        // Write-first: the new word is visible on this edge
                        vbit_q[addr] <= 1'b1;
                        Q            <= data;
                        valid        <= 1'b1;
                    end else begin
                        Q     <= rd_data;
                        valid <= vbit_q[addr];
                    end
                end
                SWEEP: begin
                    vbit_q[sweep_idx] <= 1'b0;
                    Q                 <= '0;
                    valid             <= 1'b0;
                    if (sweep_last) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_memory.sv
// Randomised scoreboard bench for word_memory (WIDTH=8, DEPTH=4).
module tb_word_memory;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk;
    logic         reset;
    logic [1:0]   addr;
    logic [W-1:0] data;
    logic         store;
    logic         clear;
    logic [W-1:0] Q;
    logic         valid;
    logic         busy;

    word_memory #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .data  (data),
        .store (store),
        .clear (clear),
        .Q     (Q),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         v;
        logic         b;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: plain arrays plus remaining-sweep-cycles count
    int   m_mem [D];
    bit   m_vb  [D];
    int   m_left = 0;

    function automatic int m_read(int a);
        return m_vb[a] ? m_mem[a] : 0;
    endfunction

    // Drive one edge's inputs, predict that edge's response, wait to negedge
    task automatic step(input bit r, input int a, input int d, input bit s,
                        input bit c, input string tag);
        exp_t e;
        reset = r;
        addr  = 2'(a);
        data  = W'(d);
        store = s;
        clear = c;
        e.tag = tag;
        if (r) begin
            for (int i = 0; i < D; i++) m_vb[i] = 0;
            m_left = 0;
            e.q = '0; e.v = 0; e.b = 0;
        end else if (m_left > 0) begin
            m_mem[D - m_left] = 0;
            m_vb[D - m_left]  = 0;
            m_left--;
            e.q = '0; e.v = 0; e.b = (m_left > 0);
        end else if (c) begin
            e.q = W'(m_read(a)); e.v = m_vb[a]; e.b = 1;
            m_left = D;
        end else if (s) begin
            m_mem[a] = d;
            m_vb[a]  = 1;
            e.q = W'(d); e.v = 1; e.b = 0;
        end else begin
            e.q = W'(m_read(a)); e.v = m_vb[a]; e.b = 0;
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every edge produces a registered response
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL no_expectation: got Q=%h valid=%b busy=%b, required none",
                         Q, valid, busy);
            end else begin
                e = sb.pop_front();
                if (Q !== e.q || valid !== e.v || busy !== e.b) begin
                    n_bad++;
                    $display("FAIL %s: got Q=%h valid=%b busy=%b, required Q=%h valid=%b busy=%b",
                             e.tag, Q, valid, busy, e.q, e.v, e.b);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < D; i++) begin
            m_mem[i] = 0;
            m_vb[i]  = 0;
        end
        step(1, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, "reset");

        for (int a = 0; a < D; a++) step(0, a, 0, 0, 0, "t1_read_after_reset");

        step(0, 2, 'hA5, 1, 0, "t2_store");
        step(0, 2, 0, 0, 0, "t2_read_back");
        step(0, 1, 0, 0, 0, "t2_read_unwritten");

        step(0, 1, 'h3C, 1, 0, "t3_write_first");
        step(0, 1, 0, 0, 0, "t3_hold");
        step(0, 1, 0, 0, 0, "t3_hold");

        for (int a = 0; a < D; a++) step(0, a, 'h11 * (a + 1), 1, 0, "t4_fill");
        step(0, 0, 0, 0, 1, "t4_clear");
        step(0, 0, 'hFF, 1, 0, "t4_store_in_sweep");
        step(0, 2, 0, 0, 1, "t4_clear_in_sweep");
        step(0, 3, 0, 0, 0, "t4_sweep");
        step(0, 1, 0, 0, 0, "t4_sweep_last");
        for (int a = 0; a < D; a++) step(0, a, 0, 0, 0, "t4_read_after_sweep");

        step(0, 3, 'h77, 1, 1, "t5_clear_and_store");
        for (int k = 0; k < D; k++) step(0, 3, 0, 0, 0, "t5_sweep");
        step(0, 3, 0, 0, 0, "t5_read_addr3");

        step(0, 0, 'h12, 1, 0, "t6_prefill");
        step(0, 0, 0, 0, 1, "t6_clear");
        step(0, 0, 0, 0, 0, "t6_sweep1");
        step(1, 0, 0, 0, 0, "t6_reset_mid_sweep");
        for (int a = 0; a < D; a++) step(0, a, 0, 0, 0, "t6_read_after_reset");
        step(0, 0, 'h5A, 1, 0, "t6_store");
        step(0, 0, 0, 0, 0, "t6_read_back");

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(63) == 0), int'($urandom_range(D - 1)),
                 int'($urandom_range(255)), bit'($urandom_range(1)),
                 ($urandom_range(15) == 0), "random");
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/word_memory.md
Name: word_memory

Overview:
Parametrised, clocked successor to the lab's single-byte store latch. It holds DEPTH words of WIDTH bits, and its output only changes when it is explicitly commanded to. It adds per-word valid tracking, write-first reads, and a multi-cycle clear sweep driven by a small FSM. It sits between switch/button input logic and display logic in the lab designs.

Parameters:
WIDTH, 8, bits per stored word
DEPTH, 4, number of words (power of two, >= 2)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
addr  input  ADDR_W  word address for store and read
data  input  WIDTH  write data
store  input  1  write data into mem[addr] on this edge
clear  input  1  start a clear sweep (pulse or level)
Q  output  WIDTH  registered read data for addr
valid  output  1  registered: word at addr has been written since the last reset/clear
busy  output  1  clear sweep in progress

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state changes occur on the rising edge of clk only. There are no latches.
- Reset (highest priority):
  - Q=0, valid=0, busy=0.
  - All valid bits cleared.
  - FSM goes to IDLE and the sweep counter goes to 0.
  - Storage array contents are not required to be cleared.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when clear=1 (and reset=0).
  - In SWEEP, each cycle: mem[cnt]=0, vbit[cnt]=0, cnt increments.
  - SWEEP -> IDLE on the cycle cnt==DEPTH-1 is written; cnt wraps to 0.
  - The sweep takes exactly DEPTH cycles.
- busy=1 for exactly the DEPTH cycles of SWEEP; it is registered (rises the edge after clear is sampled).
- clear asserted while in SWEEP is ignored; the sweep is not restarted.
- store in IDLE: on the edge, mem[addr]=data and vbit[addr]=1.
- store while busy=1 (SWEEP) is dropped silently; memory is unchanged.
- store and clear sampled high on the same IDLE edge: clear wins and store is dropped.
- Read path (1-cycle latency), every non-reset edge:
  - Q <= mem[addr] and valid <= vbit[addr], using the value before this edge's write.
  - Exception, write-first: if store is accepted to addr on this edge, Q <= data and valid <= 1.
- Read while busy:
  - Q <= 0 and valid <= 0 regardless of addr, so no partially cleared data is visible.
- Unwritten words read as valid=0; Q is then don't-care, but the bench expects 0 after any completed sweep.
- Address is always in range (DEPTH is a power of two); no bounds error exists.
- Reset mid-sweep: the sweep aborts, valid bits are cleared, busy=0 next cycle, and contents are left partially swept. This is legal because valid=0 everywhere.

Decomposition:
- Shared package (mem_pkg):
  - state enum type mem_state_t {IDLE, SWEEP}
  - default WIDTH/DEPTH constants
- One natural sub-module: sweep_counter, an ADDR_W-bit counter with enable, synchronous reset and a terminal-count flag. It is instantiated for the clear sweep.
- Storage array, valid bits and read register stay in word_memory.

Test Plan:
1. Reset, then read addr 0..3 with store=0 -> Q=0 and valid=0 on each read.
2. store data=0xA5 at addr 2; next cycle read addr 2 -> Q=0xA5, valid=1. Reads of addr 1 -> valid=0.
3. Write-first: store 0x3C at addr 1 -> Q=0x3C, valid=1 on the same edge. Hold addr 1 with store=0 -> Q stays 0x3C.
4. Fill all words (0x11,0x22,0x33,0x44), then pulse clear -> busy=1 for exactly 4 cycles and Q=0/valid=0 during the sweep. A store of 0xFF at addr 0 during the sweep is dropped. After the sweep, all addresses read Q=0, valid=0.
5. clear and store (addr 3, 0x77) on the same IDLE edge -> sweep runs; addr 3 afterwards reads valid=0, Q=0.
6. Assert reset during the 2nd sweep cycle -> busy=0 the next cycle and all valid=0. A new store at addr 0 of 0x5A is then accepted and reads back 0x5A, valid=1.
